// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// A word is accepted in IDLE, walked LSB-first for WIDTH clocks using the
// copy-until-first-one / invert-afterwards rule, then presented as
// sign + unsigned magnitude until the consumer takes it.
module twos_to_sign_mag_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_min
);

  // One extra bit so the counter can never wrap before reaching WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   mag_reg;
  logic               sign_reg;
  logic               min_reg;
  logic               seen_one;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_bit;
  logic               res_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Negative words: bits after the first 1 are inverted; everything else is copied.
  assign res_bit  = (sign_reg & seen_one) ? ~shift_reg[0] : shift_reg[0];

  assign out_sign = sign_reg;
  assign out_mag  = mag_reg;
  assign out_min  = min_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: latch on accept, one bit per clock while shifting, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      mag_reg   <= '0;
      sign_reg  <= 1'b0;
      min_reg   <= 1'b0;
      seen_one  <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      shift_reg <= in_data;
      mag_reg   <= '0;
      sign_reg  <= in_data[WIDTH-1];
      min_reg   <= in_data[WIDTH-1] & ~(|in_data[WIDTH-2:0]);
      seen_one  <= 1'b0;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      // Result enters at the MSB so bit i lands at position i after WIDTH shifts.
      mag_reg   <= {res_bit, mag_reg[WIDTH-1:1]};
      shift_reg <= shift_reg >> 1;
      seen_one  <= seen_one | shift_reg[0];
      cnt       <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Scoreboard bench for twos_to_sign_mag_serial (WIDTH=8).
module tb_twos_to_sign_mag_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [7:0] out_mag;
  logic       out_min;

  typedef struct packed {
    logic       s;
    logic [7:0] m;
    logic       mn;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  twos_to_sign_mag_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_min(out_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x);
    exp_t e;
    e.s  = x[7];
    e.m  = x[7] ? (8'd0 - x) : x;
    e.mn = (x == 8'h80);
    return e;
  endfunction

  // Output monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sign", {31'd0, out_sign}, {31'd0, e.s});
        chk("mag", {24'd0, out_mag}, {24'd0, e.m});
        chk("min", {31'd0, out_min}, {31'd0, e.mn});
      end
    end
  end

  task automatic start(input logic [7:0] d);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    while (!in_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    q.push_back(model(d));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!out_valid && l < 30);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 40);
    if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input logic [7:0] d);
    start(d);
    wait_out(lat);
    chk("latency", lat, 32'd8);
    wait_idle();
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #1 rst_n  = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {22'd0, out_sign, out_mag, out_min}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic conversions and boundaries
    convert(8'hFB);
    convert(8'h80);
    convert(8'h00);
    convert(8'h7F);
    convert(8'hFF);

    // Backpressure: outputs hold while out_ready is low
    out_ready = 1'b0;
    start(8'hC8);
    wait_out(lat);
    chk("bp_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_mag", {24'd0, out_mag}, 32'h38);
      chk("bp_hold_sign", {31'd0, out_sign}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // in_valid during SHIFT is ignored; the new word is taken only back in IDLE
    start(8'hF0);
    in_valid = 1'b1;
    in_data  = 8'h12;
    @(negedge clk);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("busy_latency", lat, 32'd8);
    wait_idle();
    @(posedge clk);
    q.push_back(model(8'h12));
    #1;
    in_valid = 1'b0;
    chk("late_accept", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("late_latency", lat, 32'd8);
    wait_idle();

    // Asynchronous reset mid-conversion
    start(8'h5A);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_outs", {22'd0, out_sign, out_mag, out_min}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    convert(8'hFE);

    // Full sweep against the model
    for (int v = 0; v < 256; v++) begin
      convert(8'(v));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
